id_issue: RTL and testbench
===========================

# id_issue

Decode-and-issue stage feeding the EX stage. It accepts one 32-bit instruction per cycle from IF/ID and reads the two source registers from the register file. It resolves RAW hazards by forwarding from the EX and MEM stages, or by a one-cycle load-use stall. It holds the ID/EX pipeline register that drives EX's reg1/reg2/aluop/waddr/write inputs.

## Interface
- Parameters: none. Widths come from shared constants: RegBus=32, RegAddrBus=5, InstBus=32, AluOpBus=8.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- inst_i  in  32  instruction word from IF/ID
- inst_valid_i  in  1  inst_i holds a real instruction
- inst_ready_o  out  1  instruction accepted this cycle (valid & ready = transfer)
- rf_raddr1_o / rf_raddr2_o  out  5  register-file read addresses (rs / rt), combinational
- rf_rdata1_i / rf_rdata2_i  in  32  register-file read data, same cycle
- ex_we_i, ex_waddr_i, ex_wdata_i  in  1/5/32  result currently produced by EX (forward source 1)
- mem_we_i, mem_waddr_i, mem_wdata_i  in  1/5/32  result in MEM (forward source 2)
- stall_i  in  1  downstream hold
- flush_i  in  1  kill the ID/EX contents
- ex_valid_o  out  1  ID/EX slot holds an instruction
- ex_aluop_o  out  8  ALU operation code
- ex_reg1_o / ex_reg2_o  out  32  operand values
- ex_waddr_o  out  5  destination register
- ex_reg_write_o  out  1  destination write enable

## Operation
- Decoded set:
  - R-type (opcode 0): OR, AND, XOR, NOR, ADDU, SUBU, SLT. reg1=rs, reg2=rt, waddr=rd.
  - ORI, ANDI, XORI: reg2 = zero-extended imm16. waddr=rt.
  - ADDIU: reg2 = sign-extended imm16.
  - LUI: reg1=0, reg2={imm16,16'h0}, aluop=OR.
  - LW: reg1=base, reg2=sign-extended offset, waddr=rt, aluop=LW.
  - Any other encoding: NOP (aluop=NOP, write=0). No trap is raised.
- Operand source priority for each read port:
  1. Register 0 always reads 0.
  2. Otherwise EX forward, if ex_we_i and ex_waddr_i==raddr.
  3. Otherwise MEM forward, if mem_we_i and mem_waddr_i==raddr.
  4. Otherwise rf_rdata.
- A port is used only when the instruction reads it. Unused ports never cause forwarding or a stall.
- Load-use hazard: the current ID/EX slot is valid LW with waddr≠0, and the incoming instruction reads that register. Required behaviour:
  - inst_ready_o=0.
  - A bubble (ex_valid_o=0, write=0, aluop=NOP) is loaded into ID/EX.
  - The instruction is re-decoded the next cycle, when the value is forwarded from MEM.
- inst_ready_o = !rst & !stall_i & !load_use. flush_i does not deassert it; an instruction offered during a flush cycle is dropped by the fetch side.
- ID/EX update, in priority order:
  1. rst: clear.
  2. flush_i: bubble.
  3. stall_i: hold all outputs.
  4. load_use: bubble.
  5. Transfer: load the decoded instruction.
  6. Otherwise: bubble.

## Timing
- All ex_* outputs are registered. An instruction accepted at edge N appears on ex_* from N to N+1.
- Reset: every ex_* output is 0, ex_valid_o=0, inst_ready_o=0 during rst.
- rf_raddr*_o are combinational from inst_i. Register-file read is zero-latency.
- Forward muxing is combinational within the accept cycle. ex_*_i refer to the instruction occupying ID/EX at that moment.
- Load-use costs exactly one bubble cycle. Back-to-back LW→LW→use stalls only on the dependent pair.
- stall_i and load_use together: hold wins, and the instruction stays un-accepted.
- flush_i and stall_i together: flush wins.
- Reset mid-stall: the slot is cleared and the pending instruction is not accepted.

## Structure
- Shared defines: opcode/funct constants, aluop codes (EXE_OR_OP, EXE_AND_OP, EXE_LW_OP, EXE_NOP_OP, …), RegBus/RegAddrBus/InstBus/AluOpBus, ZeroWord.
- Sub-module id_decode: purely combinational instruction → {aluop, re1, re2, imm, use_imm, waddr, we}.
- id_issue holds the forward muxes, hazard detect and the ID/EX register.

## Test plan
- ORI $1,$0,0x1234 accepted with rf data 0 → next cycle: aluop=OR, reg1=0, reg2=0x00001234, waddr=1, write=1, valid=1.
- OR $3,$1,$2 with ex_we_i=1, ex_waddr_i=1, ex_wdata_i=0xA5A5_0000, mem_we_i=1, mem_waddr_i=1, mem_wdata=0xFFFF_FFFF → reg1=0xA5A50000 (EX beats MEM).
- LW $4,8($5) then ADDU $6,$4,$4 → one bubble with inst_ready_o=0. The ADDU issues next cycle with reg1=reg2=mem_wdata_i.
- ORI $0,… as producer, then OR $7,$0,$0 with ex_waddr_i=0 and ex_wdata_i=0xDEAD → reg1=reg2=0.
- stall_i for 3 cycles with a valid slot → ex_* constant, inst_ready_o=0. Assert flush_i together with stall_i → ex_valid_o=0 next cycle.
- Assert rst mid-operation → all ex_* = 0 on the next edge. Opcode 0x3F → NOP with write=0.

Source files
------------

// File: rtl/id_issue_pkg.sv
// Shared widths, opcode/funct encodings, ALU op codes and the decode/ID-EX records
// used by the decode-and-issue stage.
package id_issue_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int InstBus    = 32;
    localparam int AluOpBus   = 8;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP  = 8'h00;
    localparam logic [AluOpBus-1:0] EXE_ADDU_OP = 8'h21;
    localparam logic [AluOpBus-1:0] EXE_SUBU_OP = 8'h23;
    localparam logic [AluOpBus-1:0] EXE_AND_OP  = 8'h24;
    localparam logic [AluOpBus-1:0] EXE_OR_OP   = 8'h25;
    localparam logic [AluOpBus-1:0] EXE_XOR_OP  = 8'h26;
    localparam logic [AluOpBus-1:0] EXE_NOR_OP  = 8'h27;
    localparam logic [AluOpBus-1:0] EXE_SLT_OP  = 8'h2A;
    localparam logic [AluOpBus-1:0] EXE_LW_OP   = 8'hE3;

    typedef struct packed {
        logic [AluOpBus-1:0]   aluop;
        logic [RegAddrBus-1:0] raddr1;
        logic [RegAddrBus-1:0] raddr2;
        logic                  re1;
        logic                  re2;
        logic [RegBus-1:0]     imm;
        logic                  use_imm;
        logic [RegAddrBus-1:0] waddr;
        logic                  we;
    } dec_t;

    typedef struct packed {
        logic                  valid;
        logic [AluOpBus-1:0]   aluop;
        logic [RegBus-1:0]     reg1;
        logic [RegBus-1:0]     reg2;
        logic [RegAddrBus-1:0] waddr;
        logic                  we;
    } idex_t;

    // $0 is hard zero; the younger producer (EX) shadows the older one (MEM).
    function automatic logic [RegBus-1:0] fwd_pick(
        input logic [RegAddrBus-1:0] raddr,
        input logic [RegBus-1:0]     rf_data,
        input logic                  ex_we,
        input logic [RegAddrBus-1:0] ex_waddr,
        input logic [RegBus-1:0]     ex_wdata,
        input logic                  mem_we,
        input logic [RegAddrBus-1:0] mem_waddr,
        input logic [RegBus-1:0]     mem_wdata
    );
        if (raddr == '0)                         return ZeroWord;
        else if (ex_we && ex_waddr == raddr)     return ex_wdata;
        else if (mem_we && mem_waddr == raddr)   return mem_wdata;
        else                                     return rf_data;
    endfunction

endpackage

// File: rtl/id_issue_if.sv
// Port bundle between IF/ID, register file, forwarding sources and EX for the issue stage.
interface id_issue_if;
    import id_issue_pkg::*;

    logic [InstBus-1:0]    inst_i;
    logic                  inst_valid_i;
    logic                  inst_ready_o;
    logic [RegAddrBus-1:0] rf_raddr1_o;
    logic [RegAddrBus-1:0] rf_raddr2_o;
    logic [RegBus-1:0]     rf_rdata1_i;
    logic [RegBus-1:0]     rf_rdata2_i;
    logic                  ex_we_i;
    logic [RegAddrBus-1:0] ex_waddr_i;
    logic [RegBus-1:0]     ex_wdata_i;
    logic                  mem_we_i;
    logic [RegAddrBus-1:0] mem_waddr_i;
    logic [RegBus-1:0]     mem_wdata_i;
    logic                  stall_i;
    logic                  flush_i;
    logic                  ex_valid_o;
    logic [AluOpBus-1:0]   ex_aluop_o;
    logic [RegBus-1:0]     ex_reg1_o;
    logic [RegBus-1:0]     ex_reg2_o;
    logic [RegAddrBus-1:0] ex_waddr_o;
    logic                  ex_reg_write_o;

    modport master (
        output inst_i, inst_valid_i, rf_rdata1_i, rf_rdata2_i,
               ex_we_i, ex_waddr_i, ex_wdata_i, mem_we_i, mem_waddr_i, mem_wdata_i,
               stall_i, flush_i,
        input  inst_ready_o, rf_raddr1_o, rf_raddr2_o,
               ex_valid_o, ex_aluop_o, ex_reg1_o, ex_reg2_o, ex_waddr_o, ex_reg_write_o
    );

    modport slave (
        input  inst_i, inst_valid_i, rf_rdata1_i, rf_rdata2_i,
               ex_we_i, ex_waddr_i, ex_wdata_i, mem_we_i, mem_waddr_i, mem_wdata_i,
               stall_i, flush_i,
        output inst_ready_o, rf_raddr1_o, rf_raddr2_o,
               ex_valid_o, ex_aluop_o, ex_reg1_o, ex_reg2_o, ex_waddr_o, ex_reg_write_o
    );

endinterface

// File: rtl/id_decode.sv
// Combinational instruction decoder: opcode/funct to ALU op, port usage, immediate and destination.
module id_decode
    import id_issue_pkg::*;
(
    input  logic [InstBus-1:0] inst,
    output dec_t               dec
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [RegBus-1:0] imm_zx;
    logic [RegBus-1:0] imm_sx;

    assign op     = inst[31:26];
    assign fn     = inst[5:0];
    assign imm_zx = {16'h0, inst[15:0]};
    assign imm_sx = {{16{inst[15]}}, inst[15:0]};

    always_comb begin
        dec        = '0;
        dec.aluop  = EXE_NOP_OP;
        dec.raddr1 = inst[25:21];
        dec.raddr2 = inst[20:16];
        case (op)
            OP_SPECIAL: begin
                dec.re1   = 1'b1;
                dec.re2   = 1'b1;
                dec.waddr = inst[15:11];
                dec.we    = 1'b1;
                case (fn)
                    FN_OR:   dec.aluop = EXE_OR_OP;
                    FN_AND:  dec.aluop = EXE_AND_OP;
                    FN_XOR:  dec.aluop = EXE_XOR_OP;
                    FN_NOR:  dec.aluop = EXE_NOR_OP;
                    FN_ADDU: dec.aluop = EXE_ADDU_OP;
                    FN_SUBU: dec.aluop = EXE_SUBU_OP;
                    FN_SLT:  dec.aluop = EXE_SLT_OP;
                    default: begin
                        // unknown funct degrades to a harmless NOP
                        dec.re1   = 1'b0;
                        dec.re2   = 1'b0;
                        dec.waddr = '0;
                        dec.we    = 1'b0;
                    end
                endcase
            end
            OP_ORI, OP_ANDI, OP_XORI, OP_ADDIU, OP_LW: begin
                dec.re1     = 1'b1;
                dec.use_imm = 1'b1;
                dec.waddr   = inst[20:16];
                dec.we      = 1'b1;
                case (op)
                    OP_ORI:   begin dec.aluop = EXE_OR_OP;   dec.imm = imm_zx; end
                    OP_ANDI:  begin dec.aluop = EXE_AND_OP;  dec.imm = imm_zx; end
                    OP_XORI:  begin dec.aluop = EXE_XOR_OP;  dec.imm = imm_zx; end
                    OP_ADDIU: begin dec.aluop = EXE_ADDU_OP; dec.imm = imm_sx; end
                    default:  begin dec.aluop = EXE_LW_OP;   dec.imm = imm_sx; end
                endcase
            end
            OP_LUI: begin
                dec.aluop   = EXE_OR_OP;
                dec.use_imm = 1'b1;
                dec.imm     = {inst[15:0], 16'h0};
                dec.waddr   = inst[20:16];
                dec.we      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_issue.sv
// Decode-and-issue stage: operand forwarding, load-use interlock and the ID/EX register.
module id_issue
    import id_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    id_issue_if.slave   bus
);

    dec_t              dec;
    idex_t             slot;
    logic [RegBus-1:0] src1, src2;
    logic [RegBus-1:0] op1, op2;
    logic              load_use;
    logic              ready;

    id_decode u_dec (
        .inst (bus.inst_i),
        .dec  (dec)
    );

    assign bus.rf_raddr1_o = dec.raddr1;
    assign bus.rf_raddr2_o = dec.raddr2;

    assign src1 = fwd_pick(dec.raddr1, bus.rf_rdata1_i,
                           bus.ex_we_i, bus.ex_waddr_i, bus.ex_wdata_i,
                           bus.mem_we_i, bus.mem_waddr_i, bus.mem_wdata_i);
    assign src2 = fwd_pick(dec.raddr2, bus.rf_rdata2_i,
                           bus.ex_we_i, bus.ex_waddr_i, bus.ex_wdata_i,
                           bus.mem_we_i, bus.mem_waddr_i, bus.mem_wdata_i);

    assign op1 = dec.re1 ? src1 : ZeroWord;
    assign op2 = dec.re2 ? src2 : (dec.use_imm ? dec.imm : ZeroWord);

    // LW data only exists once it reaches MEM, so a consumer right behind it waits one cycle.
    assign load_use = bus.inst_valid_i && slot.valid && (slot.aluop == EXE_LW_OP) &&
                      (slot.waddr != '0) &&
                      ((dec.re1 && dec.raddr1 == slot.waddr) ||
                       (dec.re2 && dec.raddr2 == slot.waddr));

    assign ready            = !rst && !bus.stall_i && !load_use;
    assign bus.inst_ready_o = ready;

    always_ff @(posedge clk) begin
        if (rst)
            slot <= '0;
        else if (bus.flush_i)
            slot <= '0;
        else if (bus.stall_i)
            slot <= slot;
        else if (load_use)
            slot <= '0;
        else if (bus.inst_valid_i && ready)
            slot <= '{valid: 1'b1, aluop: dec.aluop, reg1: op1, reg2: op2,
                      waddr: dec.waddr, we: dec.we};
        else
            slot <= '0;
    end

    assign bus.ex_valid_o     = slot.valid;
    assign bus.ex_aluop_o     = slot.aluop;
    assign bus.ex_reg1_o      = slot.reg1;
    assign bus.ex_reg2_o      = slot.reg2;
    assign bus.ex_waddr_o     = slot.waddr;
    assign bus.ex_reg_write_o = slot.we;

endmodule

// File: tb/tb_id_issue.sv
// Directed scoreboard bench for id_issue: driver queues hand-computed expectations,
// monitor pops one per cycle and compares ready and the ID/EX outputs.
module tb_id_issue;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_issue_if bus();

    id_issue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic [31:0] inst;
        logic        vld;
        logic [31:0] rf1, rf2;
        logic        exw;
        logic [4:0]  exa;
        logic [31:0] exd;
        logic        mw;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        stall, flush;
    } vec_t;

    typedef struct {
        string       name;
        logic        rdy;
        logic        v;
        logic [7:0]  op;
        logic [31:0] r1, r2;
        logic [4:0]  wa;
        logic        we;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic vec_t nv(input logic [31:0] inst, input logic vld);
        vec_t v;
        v = '{rst: 1'b0, inst: inst, vld: vld, rf1: 32'h0, rf2: 32'h0,
              exw: 1'b0, exa: 5'h0, exd: 32'h0, mw: 1'b0, ma: 5'h0, md: 32'h0,
              stall: 1'b0, flush: 1'b0};
        return v;
    endfunction

    function automatic exp_t ex(input string nm, input logic rdy, input logic v,
                                input logic [7:0] op, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [4:0] wa, input logic we);
        exp_t e;
        e = '{name: nm, rdy: rdy, v: v, op: op, r1: r1, r2: r2, wa: wa, we: we};
        return e;
    endfunction

    function automatic exp_t bub(input string nm, input logic rdy);
        return ex(nm, rdy, 1'b0, 8'h00, 32'h0, 32'h0, 5'h0, 1'b0);
    endfunction

    task automatic step(input vec_t v, input exp_t e);
        @(negedge clk);
        rst              = v.rst;
        bus.inst_i       = v.inst;
        bus.inst_valid_i = v.vld;
        bus.rf_rdata1_i  = v.rf1;
        bus.rf_rdata2_i  = v.rf2;
        bus.ex_we_i      = v.exw;
        bus.ex_waddr_i   = v.exa;
        bus.ex_wdata_i   = v.exd;
        bus.mem_we_i     = v.mw;
        bus.mem_waddr_i  = v.ma;
        bus.mem_wdata_i  = v.md;
        bus.stall_i      = v.stall;
        bus.flush_i      = v.flush;
        sbq.push_back(e);
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
        end
    endtask

    // Monitor: ready is checked mid-cycle, the registered slot just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk(e.name, "ready", {31'h0, bus.inst_ready_o}, {31'h0, e.rdy});
                @(posedge clk);
                #1;
                chk(e.name, "valid", {31'h0, bus.ex_valid_o},     {31'h0, e.v});
                chk(e.name, "aluop", {24'h0, bus.ex_aluop_o},     {24'h0, e.op});
                chk(e.name, "reg1",  bus.ex_reg1_o,               e.r1);
                chk(e.name, "reg2",  bus.ex_reg2_o,               e.r2);
                chk(e.name, "waddr", {27'h0, bus.ex_waddr_o},     {27'h0, e.wa});
                chk(e.name, "write", {31'h0, bus.ex_reg_write_o}, {31'h0, e.we});
            end
        end
    end

    initial begin
        vec_t v;
        bus.inst_i = '0; bus.inst_valid_i = 1'b0;
        bus.rf_rdata1_i = '0; bus.rf_rdata2_i = '0;
        bus.ex_we_i = 1'b0; bus.ex_waddr_i = '0; bus.ex_wdata_i = '0;
        bus.mem_we_i = 1'b0; bus.mem_waddr_i = '0; bus.mem_wdata_i = '0;
        bus.stall_i = 1'b0; bus.flush_i = 1'b0;

        v = nv(32'h0, 1'b0); v.rst = 1'b1;
        step(v, bub("reset0", 1'b0));
        step(v, bub("reset1", 1'b0));

        v = nv(itype(6'h0D, 5'd0, 5'd1, 16'h1234), 1'b1);
        step(v, ex("ori", 1, 1, 8'h25, 32'h0, 32'h0000_1234, 5'd1, 1));

        v = nv(rtype(5'd1, 5'd2, 5'd3, 6'h25), 1'b1);
        v.rf2 = 32'h22; v.exw = 1; v.exa = 5'd1; v.exd = 32'hA5A5_0000;
        v.mw = 1; v.ma = 5'd1; v.md = 32'hFFFF_FFFF;
        step(v, ex("or_ex_beats_mem", 1, 1, 8'h25, 32'hA5A5_0000, 32'h22, 5'd3, 1));

        v = nv(itype(6'h23, 5'd5, 5'd4, 16'h0008), 1'b1); v.rf1 = 32'h100;
        step(v, ex("lw4", 1, 1, 8'hE3, 32'h100, 32'h8, 5'd4, 1));
        v = nv(rtype(5'd4, 5'd4, 5'd6, 6'h21), 1'b1);
        step(v, bub("load_use_bubble", 1'b0));
        v.mw = 1; v.ma = 5'd4; v.md = 32'h1111_2222;
        step(v, ex("addu_after_lu", 1, 1, 8'h21, 32'h1111_2222, 32'h1111_2222, 5'd6, 1));

        v = nv(itype(6'h0D, 5'd0, 5'd0, 16'hBEEF), 1'b1);
        step(v, ex("ori_r0", 1, 1, 8'h25, 32'h0, 32'h0000_BEEF, 5'd0, 1));
        v = nv(rtype(5'd0, 5'd0, 5'd7, 6'h25), 1'b1);
        v.rf1 = 32'h55; v.rf2 = 32'h55; v.exw = 1; v.exa = 5'd0; v.exd = 32'hDEAD;
        step(v, ex("r0_no_fwd", 1, 1, 8'h25, 32'h0, 32'h0, 5'd7, 1));

        v = nv(itype(6'h23, 5'd9, 5'd8, 16'h0000), 1'b1); v.rf1 = 32'h200;
        step(v, ex("lw8", 1, 1, 8'hE3, 32'h200, 32'h0, 5'd8, 1));
        v = nv(itype(6'h23, 5'd11, 5'd10, 16'h0004), 1'b1); v.rf1 = 32'h300;
        step(v, ex("lw_lw_no_stall", 1, 1, 8'hE3, 32'h300, 32'h4, 5'd10, 1));
        v = nv(rtype(5'd10, 5'd0, 5'd12, 6'h21), 1'b1);
        step(v, bub("lw_lw_use_bubble", 1'b0));
        v.mw = 1; v.ma = 5'd10; v.md = 32'h77;
        step(v, ex("addu12", 1, 1, 8'h21, 32'h77, 32'h0, 5'd12, 1));

        v = nv(itype(6'h0E, 5'd1, 5'd13, 16'h00FF), 1'b1); v.stall = 1;
        for (int i = 0; i < 3; i++)
            step(v, ex("stall_hold", 0, 1, 8'h21, 32'h77, 32'h0, 5'd12, 1));
        v.flush = 1;
        step(v, bub("flush_beats_stall", 1'b0));

        v = nv(itype(6'h0E, 5'd1, 5'd13, 16'hFFFF), 1'b1); v.rf1 = 32'h0F0F_0000;
        step(v, ex("xori_zx", 1, 1, 8'h26, 32'h0F0F_0000, 32'h0000_FFFF, 5'd13, 1));
        v = nv(itype(6'h09, 5'd13, 5'd14, 16'hFFFE), 1'b1);
        v.rf1 = 32'h99; v.exw = 1; v.exa = 5'd13; v.exd = 32'h10;
        step(v, ex("addiu_sx", 1, 1, 8'h21, 32'h10, 32'hFFFF_FFFE, 5'd14, 1));
        v = nv(itype(6'h0F, 5'd0, 5'd15, 16'hABCD), 1'b1); v.rf1 = 32'h99;
        step(v, ex("lui", 1, 1, 8'h25, 32'h0, 32'hABCD_0000, 5'd15, 1));
        v = nv(32'hFC00_0000, 1'b1);
        step(v, ex("op3f_nop", 1, 1, 8'h00, 32'h0, 32'h0, 5'd0, 0));
        v = nv(itype(6'h0D, 5'd0, 5'd1, 16'h0001), 1'b0);
        step(v, bub("no_valid_bubble", 1'b1));
        v = nv(itype(6'h0C, 5'd2, 5'd16, 16'h8000), 1'b1); v.rf1 = 32'hFFFF_FFFF;
        step(v, ex("andi_zx", 1, 1, 8'h24, 32'hFFFF_FFFF, 32'h0000_8000, 5'd16, 1));

        v = nv(itype(6'h23, 5'd0, 5'd17, 16'h0000), 1'b1);
        step(v, ex("lw17", 1, 1, 8'hE3, 32'h0, 32'h0, 5'd17, 1));
        v = nv(rtype(5'd17, 5'd1, 5'd18, 6'h23), 1'b1); v.stall = 1;
        step(v, ex("stall_and_lu_hold", 0, 1, 8'hE3, 32'h0, 32'h0, 5'd17, 1));
        v.stall = 0;
        step(v, bub("lu_after_stall", 1'b0));
        v.mw = 1; v.ma = 5'd17; v.md = 32'h5; v.rf2 = 32'h3;
        step(v, ex("subu18", 1, 1, 8'h23, 32'h5, 32'h3, 5'd18, 1));

        v = nv(itype(6'h23, 5'd0, 5'd19, 16'h0000), 1'b1);
        step(v, ex("lw19", 1, 1, 8'hE3, 32'h0, 32'h0, 5'd19, 1));
        v = nv(itype(6'h0F, 5'd19, 5'd22, 16'h0001), 1'b1);
        v.exw = 1; v.exa = 5'd19; v.exd = 32'hBAD;
        step(v, ex("unused_port_no_stall", 1, 1, 8'h25, 32'h0, 32'h0001_0000, 5'd22, 1));

        v = nv(itype(6'h23, 5'd0, 5'd23, 16'h0000), 1'b1);
        step(v, ex("lw23", 1, 1, 8'hE3, 32'h0, 32'h0, 5'd23, 1));
        v = nv(rtype(5'd23, 5'd0, 5'd24, 6'h21), 1'b1); v.stall = 1; v.rst = 1; v.rf1 = 32'h44;
        step(v, bub("reset_mid_stall", 1'b0));
        v.stall = 0; v.rst = 0;
        step(v, ex("after_reset", 1, 1, 8'h21, 32'h44, 32'h0, 5'd24, 1));
        v = nv(itype(6'h0D, 5'd0, 5'd1, 16'h0001), 1'b1); v.flush = 1;
        step(v, bub("flush_alone", 1'b1));

        repeat (3) @(negedge clk);
        chk("drain", "queue", sbq.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
